// File: rtl/exc_pkg.sv
// Shared constants for the exception controller: exception codes, vectors,
// CP0 register numbers and the handler FSM state type.
package exc_pkg;

  localparam logic [4:0]  EXC_INT      = 5'd0;
  localparam logic [4:0]  EXC_SYS      = 5'd8;
  localparam logic [4:0]  EXC_OV       = 5'd12;

  localparam logic [31:0] VEC_EXC      = 32'h8000_0180;
  localparam logic [31:0] VEC_IRQ_BASE = 32'h8000_0200;

  localparam logic [4:0]  CP0_STATUS   = 5'd12;
  localparam logic [4:0]  CP0_CAUSE    = 5'd13;
  localparam logic [4:0]  CP0_EPC      = 5'd14;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  // Index of the lowest set bit; callers only use it when some bit is set.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for level-sensitive interrupt lines coming from
// outside the clk domain.
module irq_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// CP0-style exception controller: Status/Cause/EPC, overflow/syscall/irq
// prioritisation, eret return. Define VECTORED_IRQ_EN for per-line irq vectors.
module exc_ctrl
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ovf_i,
  input  logic        sys_i,
  input  logic        eret_i,
  input  logic [3:0]  irq_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_addr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] cp0_rdata_o,
  output logic        redirect_o,
  output logic [31:0] vector_o,
  output logic        flush_o,
  output logic        exl_o
);

  state_t      r_state, w_state_next;
  logic        r_ie, w_ie_next;
  logic [3:0]  r_im, w_im_next;
  logic [4:0]  r_exc_code, w_exc_code_next;
  logic [31:0] r_epc, w_epc_next;

  logic [3:0]  w_ip;
  logic [3:0]  w_pend;
  logic        w_exl;
  logic        w_irq;
  logic        w_event;
  logic        w_eret;
  logic [31:0] w_event_vec;
  logic        w_unused_wdata;

  irq_sync #(.WIDTH(4)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d_i (irq_i),
    .q_o (w_ip)
  );

  assign w_exl   = (r_state == ST_HANDLER);
  assign w_pend  = w_ip & r_im;
  assign w_irq   = (|w_pend) && r_ie && !w_exl;
  assign w_event = ovf_i || sys_i || w_irq;
  assign w_eret  = eret_i && w_exl && !w_event;

  assign w_unused_wdata = ^{cp0_wdata_i[31:14], cp0_wdata_i[9:7], cp0_wdata_i[1:0]};

`ifdef VECTORED_IRQ_EN
  assign w_event_vec = (ovf_i || sys_i) ? VEC_EXC
                     : VEC_IRQ_BASE + {25'd0, lowest_idx(w_pend), 5'd0};
`else
  assign w_event_vec = VEC_EXC;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_ie_next       = r_ie;
    w_im_next       = r_im;
    w_exc_code_next = r_exc_code;
    w_epc_next      = r_epc;
    redirect_o      = 1'b0;
    flush_o         = 1'b0;
    vector_o        = 32'd0;

    // mtc0 first so a coinciding event overrides only the fields it owns.
    if (cp0_we_i) begin
      case (cp0_addr_i)
        CP0_STATUS: begin
          w_ie_next    = cp0_wdata_i[0];
          w_im_next    = cp0_wdata_i[13:10];
          w_state_next = cp0_wdata_i[1] ? ST_HANDLER : ST_RUN;
        end
        CP0_CAUSE: w_exc_code_next = cp0_wdata_i[6:2];
        CP0_EPC:   w_epc_next      = cp0_wdata_i;
        default:   ;
      endcase
    end

    if (w_event) begin
      w_state_next    = ST_HANDLER;
      w_exc_code_next = ovf_i ? EXC_OV : (sys_i ? EXC_SYS : EXC_INT);
      if (!w_exl) w_epc_next = (sys_i && !ovf_i) ? pc_i + 32'd4 : pc_i;
      redirect_o = 1'b1;
      flush_o    = 1'b1;
      vector_o   = w_event_vec;
    end else if (w_eret) begin
      w_state_next = ST_RUN;
      redirect_o   = 1'b1;
      vector_o     = r_epc;
    end

    if (rst) begin
      redirect_o = 1'b0;
      flush_o    = 1'b0;
      vector_o   = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_ie       <= 1'b0;
      r_im       <= 4'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_ie       <= w_ie_next;
      r_im       <= w_im_next;
      r_exc_code <= w_exc_code_next;
      r_epc      <= w_epc_next;
    end
  end

  always_comb begin
    case (cp0_addr_i)
      CP0_STATUS: cp0_rdata_o = {18'd0, r_im, 8'd0, w_exl, r_ie};
      CP0_CAUSE:  cp0_rdata_o = {18'd0, w_ip, 3'd0, r_exc_code, 2'd0};
      CP0_EPC:    cp0_rdata_o = r_epc;
      default:    cp0_rdata_o = 32'd0;
    endcase
  end

  assign exl_o = w_exl;

endmodule
